// File: rtl/stack_xfer_seq_if.sv
// Port bundle for the PUSH/POP transfer sequencer. The master side is the
// sequencer; the slave side is the decode/register-file/memory environment.
interface stack_xfer_seq_if #(
  parameter int AW = 16,
  parameter int DW = 16
) ();
  logic          start;
  logic          is_push;
  logic [8:0]    RL;
  logic [AW-1:0] SP_in;
  logic [DW-1:0] rf_rdata;
  logic [DW-1:0] lr_in;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;

  logic          busy;
  logic          dmem_en;
  logic          dmem_wr;
  logic [AW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata;
  logic [2:0]    rf_raddr;
  logic [2:0]    rf_waddr;
  logic          rf_wr;
  logic          pc_wr;
  logic [AW-1:0] SP_out;
  logic          sp_wr;
  logic          done;

  modport master (
    input  start, is_push, RL, SP_in, rf_rdata, lr_in, mem_rdata, mem_ready,
    output busy, dmem_en, dmem_wr, dmem_addr, dmem_wdata, rf_raddr, rf_waddr,
           rf_wr, pc_wr, SP_out, sp_wr, done
  );

  modport slave (
    output start, is_push, RL, SP_in, rf_rdata, lr_in, mem_rdata, mem_ready,
    input  busy, dmem_en, dmem_wr, dmem_addr, dmem_wdata, rf_raddr, rf_waddr,
           rf_wr, pc_wr, SP_out, sp_wr, done
  );
endinterface

// File: rtl/stack_xfer_seq.sv
// Expands one decoded PUSH/POP register list into per-register data-memory
// accesses, then issues the final SP update and a completion pulse.
module stack_xfer_seq #(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic             clk,
  input  logic             reset,
  stack_xfer_seq_if.master bus
);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t        state;
  logic          push_q;
  logic [8:0]    mask;
  logic [AW-1:0] base;
  logic [3:0]    k;
  logic [3:0]    n;
  logic [AW-1:0] sp_out;

  logic [3:0]    slot;
  logic [3:0]    rl_count;
  logic          xfer;
  logic          fire;
  logic [8:0]    mask_next;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    slot = '0;
    for (int i = 8; i >= 0; i--) begin
      if (mask[i]) slot = 4'(i);
    end
  end

  always_comb begin
    rl_count = '0;
    for (int i = 0; i < 9; i++) begin
      rl_count = rl_count + {3'b000, bus.RL[i]};
    end
  end

  // Reset gates the strobes combinationally so an abort never issues one more access.
  assign xfer      = (state == XFER) && !reset;
  assign fire      = xfer && bus.mem_ready;
  assign mask_next = mask & (mask - 9'd1);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      push_q <= 1'b0;
      mask   <= '0;
      base   <= '0;
      k      <= '0;
      n      <= '0;
      sp_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            push_q <= bus.is_push;
            mask   <= bus.RL;
            n      <= rl_count;
            k      <= '0;
            base   <= bus.is_push ? bus.SP_in - AW'(rl_count) : bus.SP_in;
            if (rl_count == 4'd0) begin
              sp_out <= bus.SP_in;
              state  <= DONE;
            end else begin
              state  <= XFER;
            end
          end
        end
        XFER: begin
          if (bus.mem_ready) begin
            mask <= mask_next;
            k    <= k + 4'd1;
            if (mask_next == 9'd0) begin
              sp_out <= push_q ? base : base + AW'(n);
              state  <= DONE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy       = (state != IDLE) && !reset;
  assign bus.dmem_en    = xfer;
  assign bus.dmem_wr    = xfer && push_q;
  assign bus.dmem_addr  = xfer ? base + AW'(k) : '0;
  assign bus.dmem_wdata = (xfer && push_q) ? ((slot == 4'd8) ? bus.lr_in : bus.rf_rdata) : '0;
  assign bus.rf_raddr   = (xfer && push_q) ? slot[2:0] : '0;
  assign bus.rf_waddr   = (xfer && !push_q) ? slot[2:0] : '0;
  assign bus.rf_wr      = fire && !push_q && !slot[3];
  assign bus.pc_wr      = fire && !push_q && slot[3];
  assign bus.sp_wr      = (state == DONE) && !reset;
  assign bus.done       = (state == DONE) && !reset;
  assign bus.SP_out     = sp_out;

  // Read data goes straight to the register file / PC; the sequencer only strobes.
  logic unused_rdata;
  assign unused_rdata = ^bus.mem_rdata;

endmodule

// File: tb/tb_stack_xfer_seq.sv
// Directed self-checking bench for stack_xfer_seq: PUSH/POP expansion, stalls,
// empty list, address wrap, mid-operation reset and ignored start.
module tb_stack_xfer_seq;
  localparam int AW = 16;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  stack_xfer_seq_if #(.AW(AW), .DW(DW)) bus ();
  stack_xfer_seq #(.AW(AW), .DW(DW)) dut (.clk(clk), .reset(reset), .bus(bus));

  // Register file returns 0xA000 + index; LR is a fixed pattern.
  assign bus.rf_rdata  = {13'h1400, bus.rf_raddr};
  assign bus.lr_in     = 16'hBEEF;
  assign bus.mem_rdata = bus.dmem_addr ^ 16'h5A5A;

  int n_checks = 0;
  int n_pass   = 0;
  int n_rf_wr  = 0;
  int n_pc_wr  = 0;
  int n_done   = 0;
  int n_sp_wr  = 0;

  always @(negedge clk) begin
    if (bus.rf_wr) n_rf_wr++;
    if (bus.pc_wr) n_pc_wr++;
    if (bus.done)  n_done++;
    if (bus.sp_wr) n_sp_wr++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push_access(input string tag, input logic [15:0] addr, input logic [15:0] wdata);
    check({tag, "_busy_en_wr"}, {bus.busy, bus.dmem_en, bus.dmem_wr}, 3'b111);
    check({tag, "_addr"}, bus.dmem_addr, addr);
    check({tag, "_wdata"}, bus.dmem_wdata, wdata);
  endtask

  task automatic pop_access(input string tag, input logic [15:0] addr, input bit chk_waddr,
                            input logic [2:0] waddr, input logic [1:0] rf_pc);
    check({tag, "_busy_en_wr"}, {bus.busy, bus.dmem_en, bus.dmem_wr}, 3'b110);
    check({tag, "_addr"}, bus.dmem_addr, addr);
    if (chk_waddr) check({tag, "_waddr"}, bus.rf_waddr, waddr);
    check({tag, "_rfwr_pcwr"}, {bus.rf_wr, bus.pc_wr}, rf_pc);
  endtask

  task automatic done_check(input string tag, input logic [15:0] sp);
    check({tag, "_busy_en_spwr_done"}, {bus.busy, bus.dmem_en, bus.sp_wr, bus.done}, 4'b1011);
    check({tag, "_sp_out"}, bus.SP_out, sp);
  endtask

  task automatic request(input logic push, input logic [8:0] rl, input logic [15:0] sp);
    bus.start   = 1'b1;
    bus.is_push = push;
    bus.RL      = rl;
    bus.SP_in   = sp;
  endtask

  initial begin
    int rf0, pc0, dn0, sp0;

    // Reset held together with start: reset must win.
    reset         = 1'b1;
    bus.mem_ready = 1'b1;
    request(1'b0, 9'h001, 16'h0040);
    repeat (2) next_cycle();
    bus.start = 1'b0;
    reset     = 1'b0;
    #1;
    check("rst_outs", {bus.busy, bus.dmem_en, bus.dmem_wr, bus.rf_wr, bus.pc_wr, bus.sp_wr, bus.done}, 7'd0);
    check("rst_sp_out", bus.SP_out, 16'h0000);
    next_cycle();
    check("rst_prio_busy", bus.busy, 1'b0);

    // PUSH {R0,R2,LR} from SP=0x0100.
    request(1'b1, 9'h105, 16'h0100);
    next_cycle(); bus.start = 1'b0; #1;
    push_access("push_r0", 16'h00FD, 16'hA000);
    next_cycle(); push_access("push_r2", 16'h00FE, 16'hA002);
    next_cycle(); push_access("push_lr", 16'h00FF, 16'hBEEF);
    next_cycle(); done_check("push_done", 16'h00FD);
    next_cycle();
    check("push_after", {bus.busy, bus.sp_wr, bus.done}, 3'b000);
    check("push_sp_hold", bus.SP_out, 16'h00FD);

    // POP {R1,PC} from SP=0x00FE with a two-cycle stall and a stray start.
    dn0 = n_done;
    bus.mem_ready = 1'b0;
    request(1'b0, 9'h102, 16'h00FE);
    next_cycle(); bus.start = 1'b0; #1;
    pop_access("pop_wait1", 16'h00FE, 1'b1, 3'd1, 2'b00);
    next_cycle();
    request(1'b1, 9'h0FF, 16'h5555);
    #1;
    pop_access("pop_wait2", 16'h00FE, 1'b1, 3'd1, 2'b00);
    next_cycle(); bus.start = 1'b0; bus.mem_ready = 1'b1; #1;
    pop_access("pop_r1", 16'h00FE, 1'b1, 3'd1, 2'b10);
    next_cycle(); pop_access("pop_pc", 16'h00FF, 1'b0, 3'd0, 2'b01);
    next_cycle(); done_check("pop_done", 16'h0100);
    next_cycle();
    check("pop_idle", {bus.busy, bus.done, bus.dmem_en}, 3'b000);
    check("pop_done_count", n_done - dn0, 1);

    // Empty list: straight to DONE, no access.
    request(1'b1, 9'h000, 16'h1234);
    next_cycle(); bus.start = 1'b0; #1;
    done_check("empty_done", 16'h1234);
    next_cycle();
    check("empty_idle", bus.busy, 1'b0);

    // PUSH {R0,R1,R2} from SP=0x0001: addresses wrap through 0xFFFF.
    request(1'b1, 9'h007, 16'h0001);
    next_cycle(); bus.start = 1'b0; #1;
    push_access("wrap_r0", 16'hFFFE, 16'hA000);
    next_cycle(); push_access("wrap_r1", 16'hFFFF, 16'hA001);
    next_cycle(); push_access("wrap_r2", 16'h0000, 16'hA002);
    next_cycle(); done_check("wrap_done", 16'hFFFE);

    // POP all nine, reset after the fourth transfer.
    next_cycle();
    rf0 = n_rf_wr; pc0 = n_pc_wr; dn0 = n_done; sp0 = n_sp_wr;
    request(1'b0, 9'h1FF, 16'h2000);
    next_cycle(); bus.start = 1'b0; #1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) next_cycle();
      pop_access($sformatf("abort_r%0d", i), 16'h2000 + 16'(i), 1'b1, 3'(i), 2'b10);
    end
    next_cycle(); reset = 1'b1; #1;
    check("abort_no_access", {bus.dmem_en, bus.rf_wr, bus.pc_wr}, 3'b000);
    next_cycle(); reset = 1'b0; #1;
    check("abort_outs", {bus.busy, bus.dmem_en, bus.dmem_wr, bus.rf_wr, bus.pc_wr, bus.sp_wr, bus.done}, 7'd0);
    check("abort_sp_out", bus.SP_out, 16'h0000);
    check("abort_rf_wr_count", n_rf_wr - rf0, 4);
    check("abort_other_count", (n_pc_wr - pc0) + (n_done - dn0) + (n_sp_wr - sp0), 0);

    // A fresh request is accepted right after the abort.
    request(1'b1, 9'h001, 16'h0010);
    next_cycle(); bus.start = 1'b0; #1;
    push_access("post_rst_r0", 16'h000F, 16'hA000);
    next_cycle(); done_check("post_rst_done", 16'h000F);

    next_cycle();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
